// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the RV32I fetch stage: instruction constants,
// the FSM state type and the IF/ID pipeline register layout.
package core_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [XLEN-1:0] EBREAK_INSTR = 32'h0010_0073;

   typedef enum logic {RUN, HALT} fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic            valid;
   } if_id_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: hazard/redirect controls, ROM port and IF/ID outputs.
interface fetch_if #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32
);
   logic              stall;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic [DATA_W-1:0] if_instr;
   logic [31:0]       if_pc;
   logic              if_valid;
   logic              misalign_err;
   logic              halted;
   logic [31:0]       fetch_count;

   modport master (
      input  stall, redirect, redirect_pc, rom_data,
      output rom_addr, if_instr, if_pc, if_valid, misalign_err, halted, fetch_count
   );

   modport slave (
      output stall, redirect, redirect_pc, rom_data,
      input  rom_addr, if_instr, if_pc, if_valid, misalign_err, halted, fetch_count
   );
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter with next-PC mux: redirect, then hold/stall, then +4.
module pc_reg
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            redirect_i,
   input  logic            stall_i,
   input  logic            hold_i,
   input  logic [XLEN-1:2] redirect_word_i,
   output logic [XLEN-1:0] pc_o
);

   logic [XLEN-1:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q + 32'd4;
      if (redirect_i) begin
         pc_d = {redirect_word_i, 2'b00};
      end else if (stall_i || hold_i) begin
         pc_d = pc_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: drives the async ROM from the PC register
// and captures the returned word into IF/ID, with stall, redirect and halt.
module fetch_unit
   import core_pkg::*;
#(
   parameter int unsigned     ADDR_W   = 10,
   parameter int unsigned     DATA_W   = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input logic       reloj,
   input logic       reset,
   fetch_if.master   bus
);

   fetch_state_t    state_q, state_d;
   if_id_t          if_id_q, if_id_d;
   logic            misalign_q, misalign_d;
   logic [31:0]     count_q, count_d;
   logic [XLEN-1:0] pc;
   logic            hold;
   logic            redirect_run;

   assign redirect_run = bus.redirect && (state_q == RUN);

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk_i           (reloj),
      .reset_i         (reset),
      .redirect_i      (redirect_run),
      .stall_i         (bus.stall),
      .hold_i          (hold),
      .redirect_word_i (bus.redirect_pc[XLEN-1:2]),
      .pc_o            (pc)
   );

   always_comb begin
      state_d    = state_q;
      if_id_d    = if_id_q;
      misalign_d = 1'b0;
      count_d    = count_q;
      hold       = 1'b0;
      unique case (state_q)
         RUN: begin
            if (bus.redirect) begin
               if_id_d.instr = NOP_INSTR;
               if_id_d.valid = 1'b0;
               misalign_d    = (bus.redirect_pc[1:0] != 2'b00);
            end else if (!bus.stall) begin
               if_id_d.instr = bus.rom_data;
               if_id_d.pc    = pc;
               if_id_d.valid = 1'b1;
               count_d       = count_q + 32'd1;
               // EBREAK is delivered, but the PC stays on it from this edge on.
               if (bus.rom_data == EBREAK_INSTR) begin
                  state_d = HALT;
                  hold    = 1'b1;
               end
            end
         end
         HALT: begin
            hold          = 1'b1;
            if_id_d.instr = NOP_INSTR;
            if_id_d.valid = 1'b0;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge reloj) begin
      if (reset) begin
         state_q    <= RUN;
         if_id_q    <= '{instr: NOP_INSTR, pc: RESET_PC, valid: 1'b0};
         misalign_q <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         if_id_q    <= if_id_d;
         misalign_q <= misalign_d;
         count_q    <= count_d;
      end
   end

   assign bus.rom_addr     = pc[ADDR_W+1:2];
   assign bus.if_instr     = if_id_q.instr;
   assign bus.if_pc        = if_id_q.pc;
   assign bus.if_valid     = if_id_q.valid;
   assign bus.misalign_err = misalign_q;
   assign bus.halted       = (state_q == HALT);
   assign bus.fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, halt, stall, redirect,
// misaligned redirect, 4 KiB wrap and reset during stall.
module tb_fetch_unit;

   logic reloj = 1'b0;
   logic reset;

   fetch_if #(.ADDR_W(10), .DATA_W(32)) fif ();

   fetch_unit #(
      .ADDR_W   (10),
      .DATA_W   (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .reloj (reloj),
      .reset (reset),
      .bus   (fif)
   );

   logic [31:0] mem [1024];
   assign fif.rom_data = mem[fif.rom_addr];

   always #5 reloj = ~reloj;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic edge1();
      @(posedge reloj);
      #1;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " rom_addr"}, 32'(fif.rom_addr), 32'd0);
      chk({tag, " if_instr"}, fif.if_instr, 32'h0000_0013);
      chk({tag, " if_pc"}, fif.if_pc, 32'd0);
      chk({tag, " if_valid"}, 32'(fif.if_valid), 32'd0);
      chk({tag, " misalign"}, 32'(fif.misalign_err), 32'd0);
      chk({tag, " halted"}, 32'(fif.halted), 32'd0);
      chk({tag, " count"}, fif.fetch_count, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
      mem[0] = 32'h0ff00013;
      mem[1] = 32'h0ff08093;
      mem[2] = 32'h0ff10113;
      mem[3] = 32'h0ff18193;
      mem[4] = 32'h00100073;

      reset = 1'b1;
      fif.stall = 1'b0;
      fif.redirect = 1'b0;
      fif.redirect_pc = '0;
      edge1();
      edge1();
      chk_reset_state("rst0");

      // Sequential fetch
      reset = 1'b0;
      edge1(); chk("seq0 instr", fif.if_instr, 32'h0ff00013); chk("seq0 pc", fif.if_pc, 32'h0);
      chk("seq0 valid", 32'(fif.if_valid), 32'd1);
      edge1(); chk("seq1 instr", fif.if_instr, 32'h0ff08093); chk("seq1 pc", fif.if_pc, 32'h4);
      edge1(); chk("seq2 instr", fif.if_instr, 32'h0ff10113); chk("seq2 pc", fif.if_pc, 32'h8);
      edge1(); chk("seq3 instr", fif.if_instr, 32'h0ff18193); chk("seq3 pc", fif.if_pc, 32'hC);
      chk("seq count", fif.fetch_count, 32'd4);

      // Halt on EBREAK at word 4
      edge1();
      chk("ebrk instr", fif.if_instr, 32'h00100073);
      chk("ebrk valid", 32'(fif.if_valid), 32'd1);
      chk("ebrk pc", fif.if_pc, 32'h10);
      chk("ebrk count", fif.fetch_count, 32'd5);
      chk("ebrk rom_addr", 32'(fif.rom_addr), 32'd4);
      edge1();
      chk("halt halted", 32'(fif.halted), 32'd1);
      chk("halt valid", 32'(fif.if_valid), 32'd0);
      chk("halt instr", fif.if_instr, 32'h0000_0013);
      chk("halt rom_addr", 32'(fif.rom_addr), 32'd4);
      fif.redirect = 1'b1; fif.redirect_pc = 32'h0000_0200;
      edge1();
      fif.redirect = 1'b0;
      chk("halt redir rom_addr", 32'(fif.rom_addr), 32'd4);
      chk("halt redir valid", 32'(fif.if_valid), 32'd0);
      chk("halt redir halted", 32'(fif.halted), 32'd1);
      chk("halt redir misalign", 32'(fif.misalign_err), 32'd0);
      edge1();
      chk("halt count", fif.fetch_count, 32'd5);
      reset = 1'b1;
      edge1();
      chk_reset_state("rst1");

      // Stall while if_pc = 4
      reset = 1'b0;
      edge1();
      edge1();
      chk("pre-stall pc", fif.if_pc, 32'h4);
      fif.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         edge1();
         chk("stall instr", fif.if_instr, 32'h0ff08093);
         chk("stall pc", fif.if_pc, 32'h4);
         chk("stall rom_addr", 32'(fif.rom_addr), 32'd2);
         chk("stall count", fif.fetch_count, 32'd2);
      end
      fif.stall = 1'b0;
      edge1();
      chk("post-stall instr", fif.if_instr, 32'h0ff10113);
      chk("post-stall pc", fif.if_pc, 32'h8);
      chk("post-stall count", fif.fetch_count, 32'd3);

      // Redirect together with stall
      fif.redirect = 1'b1; fif.redirect_pc = 32'h0000_0100; fif.stall = 1'b1;
      edge1();
      fif.redirect = 1'b0; fif.stall = 1'b0;
      chk("redir valid", 32'(fif.if_valid), 32'd0);
      chk("redir instr", fif.if_instr, 32'h0000_0013);
      chk("redir rom_addr", 32'(fif.rom_addr), 32'd64);
      chk("redir misalign", 32'(fif.misalign_err), 32'd0);
      chk("redir count", fif.fetch_count, 32'd3);
      edge1();
      chk("tgt instr", fif.if_instr, 32'hA000_0040);
      chk("tgt pc", fif.if_pc, 32'h100);
      chk("tgt valid", 32'(fif.if_valid), 32'd1);
      chk("tgt misalign", 32'(fif.misalign_err), 32'd0);

      // Misaligned redirect
      fif.redirect = 1'b1; fif.redirect_pc = 32'h0000_0106;
      edge1();
      fif.redirect = 1'b0;
      chk("mis err", 32'(fif.misalign_err), 32'd1);
      chk("mis rom_addr", 32'(fif.rom_addr), 32'd65);
      edge1();
      chk("mis err clear", 32'(fif.misalign_err), 32'd0);
      chk("mis instr", fif.if_instr, 32'hA000_0041);
      chk("mis pc", fif.if_pc, 32'h104);

      // 4 KiB wrap
      fif.redirect = 1'b1; fif.redirect_pc = 32'h0000_0FFC;
      edge1();
      fif.redirect = 1'b0;
      chk("wrap rom_addr", 32'(fif.rom_addr), 32'd1023);
      edge1();
      chk("wrap instr1023", fif.if_instr, 32'hA000_03FF);
      chk("wrap pc1023", fif.if_pc, 32'h0FFC);
      chk("wrap rom_addr0", 32'(fif.rom_addr), 32'd0);
      edge1();
      chk("wrap instr0", fif.if_instr, 32'h0ff00013);
      chk("wrap pc1000", fif.if_pc, 32'h1000);
      chk("wrap misalign", 32'(fif.misalign_err), 32'd0);

      // Reset in the middle of a stall
      fif.stall = 1'b1;
      edge1();
      chk("mid stall pc", fif.if_pc, 32'h1000);
      reset = 1'b1;
      edge1();
      chk_reset_state("rst2");
      reset = 1'b0; fif.stall = 1'b0;
      edge1();
      chk("restart instr", fif.if_instr, 32'h0ff00013);
      chk("restart count", fif.fetch_count, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
